// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between I-fetch and D load/store, with D priority, starvation bound and timeout watchdog.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] starve_cnt;
  logic [7:0] wd_cnt;
  logic gnt_d, gnt_i, busy, done, abort, fin;
  always_comb begin
    gnt_d = state == IDLE && d_req && (!if_req || starve_cnt != 4'(STARVE_LIMIT));
    gnt_i = state == IDLE && !gnt_d && if_req;
    busy = state == GNT_I || state == GNT_D;
    done = busy && mem_ack;
    abort = busy && !mem_ack && wd_cnt == 8'(TIMEOUT - 1);
    fin = done || abort;
    state_nx = state == RESP ? IDLE : gnt_d ? GNT_D : gnt_i ? GNT_I : fin ? RESP : state;
  end
  assign stall_if = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      wd_cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_byte <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      if_valid <= fin && state == GNT_I;
      d_valid <= fin && state == GNT_D;
      if (gnt_d || gnt_i) begin
        mem_req <= 1'b1;
        mem_we <= gnt_d & d_we;
        mem_byte <= gnt_d & d_byte;
        mem_addr <= gnt_d ? d_addr : if_addr;
        mem_wdata <= gnt_d ? d_wdata : '0;
        wd_cnt <= '0;
        // a D grant with I pending is only possible below the limit, so +1 never overshoots
        starve_cnt <= (gnt_d && if_req) ? starve_cnt + 4'd1 : '0;
      end else if (busy) begin
        mem_req <= !fin;
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (abort) bus_err <= 1'b1;
      if (fin && state == GNT_I) if_rdata <= abort ? 32'hDEADBEEF : mem_rdata;
      if (fin && state == GNT_D) d_rdata <= abort ? 32'hDEADBEEF : mem_we ? '0 : mem_rdata;
    end
endmodule
